// File: rtl/itch_encode_pkg.sv
// Shared types and constants for the ITCH 5.0 transmit-side encoders.
package itch_encode_pkg;

  localparam logic [7:0]  ITCH_MSG_REPLACE = 8'h55;
  localparam int unsigned ITCH_LEN_REPLACE = 27;

  // Replace Order payload fields, in wire order
  typedef struct packed {
    logic [63:0] old_ref;
    logic [63:0] new_ref;
    logic [31:0] shares;
    logic [31:0] price;
  } replace_fields_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } enc_state_t;

endpackage

// File: rtl/itch_byte_serializer.sv
// Parallel-load shift register that emits a LEN-byte message MSB-first, one byte per cycle.
module itch_byte_serializer #(
  parameter int unsigned LEN = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [LEN*8-1:0]     data_i,
  output logic [7:0]           byte_o,
  output logic                 valid_o,
  output logic                 first_o,
  output logic                 last_o,
  output logic                 last_nx_c
);

  localparam int unsigned BITS  = LEN * 8;
  localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  logic [BITS-1:0]  data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;

  // Load has priority; otherwise shift until the last byte, then clear so the output reads zero.
  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && !last_q) begin
      data_d = {data_q[BITS-9:0], 8'h00};
      idx_d  = idx_q + IDX_W'(1);
    end else if (valid_q) begin
      data_d  = '0;
      idx_d   = '0;
      valid_d = 1'b0;
    end
    first_d = load_i;
    last_d  = valid_d && (idx_d == LAST_IDX);
  end

  assign last_nx_c = last_d;

  // Byte register, index and framing flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign byte_o  = data_q[BITS-1 -: 8];
  assign valid_o = valid_q;
  assign first_o = first_q;
  assign last_o  = last_q;

endmodule

// File: rtl/replace_order_encoder.sv
// ITCH 5.0 Replace Order ('U') encoder: one-deep field buffer feeding a gap-free byte stream.
module replace_order_encoder
  import itch_encode_pkg::*;
#(
  parameter logic [7:0]  MSG_TYPE = ITCH_MSG_REPLACE,
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_old_order_ref,
  input  logic [63:0] in_new_order_ref,
  input  logic [31:0] in_shares,
  input  logic [31:0] in_price,
  output logic [7:0]  byte_out,
  output logic        valid_out,
  output logic        msg_start,
  output logic        msg_done,
  output logic        busy,
  output logic [15:0] msg_count
);

  localparam int unsigned MSG_LENGTH = ITCH_LEN_REPLACE;
  localparam int unsigned MSG_BITS   = MSG_LENGTH * 8;
  localparam int unsigned GAP_W      = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  enc_state_t      state_q, state_d;
  replace_fields_t pending_q, pending_d;
  logic            pending_valid_q, pending_valid_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [15:0]     count_q, count_d;

  replace_fields_t     in_fields_c;
  logic [MSG_BITS-1:0] msg_c;
  logic                load_c;
  logic                ser_last;
  logic                ser_last_nx_c;

  assign in_fields_c = {in_old_order_ref, in_new_order_ref, in_shares, in_price};

  // Wire image of the pending field set: type, refs, shares, price, two reserved bytes
  assign msg_c = {MSG_TYPE, pending_q, 16'h0000};

  // Next-state: message sequencing, pending buffer and registered status outputs
  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    gap_cnt_d       = gap_cnt_q;
    count_d         = count_q;
    load_c          = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_valid_q) begin
          load_c  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ser_last) begin
          if (IDLE_GAP > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_W'(IDLE_GAP - 1);
          end else if (pending_valid_q) begin
            load_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          if (pending_valid_q) begin
            load_c  = 1'b1;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Transfer consumes the old contents; a same-cycle handshake refills the buffer
    if (load_c) pending_valid_d = 1'b0;
    if (in_valid && ready_q) begin
      pending_d       = in_fields_c;
      pending_valid_d = 1'b1;
    end

    if (ser_last_nx_c) count_d = count_q + 16'd1;

    ready_d = !pending_valid_d;
    busy_d  = (state_d != IDLE) || pending_valid_d;
  end

  // State and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      gap_cnt_q       <= '0;
      ready_q         <= 1'b1;
      busy_q          <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      gap_cnt_q       <= gap_cnt_d;
      ready_q         <= ready_d;
      busy_q          <= busy_d;
      count_q         <= count_d;
    end
  end

  itch_byte_serializer #(
    .LEN (MSG_LENGTH)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_c),
    .data_i    (msg_c),
    .byte_o    (byte_out),
    .valid_o   (valid_out),
    .first_o   (msg_start),
    .last_o    (ser_last),
    .last_nx_c (ser_last_nx_c)
  );

  assign msg_done  = ser_last;
  assign in_ready  = ready_q;
  assign busy      = busy_q;
  assign msg_count = count_q;

endmodule

// File: tb/tb_replace_order_encoder.sv
// Self-checking bench: two encoders (IDLE_GAP=0 and IDLE_GAP=3) against a timeline reference model.
module tb_replace_order_encoder;
  import itch_encode_pkg::*;

  // Output vector layout: {valid, byte[7:0], start, done, ready, busy, count[15:0]}
  localparam logic [28:0] RST_VEC = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};

  logic            clk;
  logic            rst_n;
  logic            in_valid [2];
  replace_fields_t in_f [2];
  logic            in_ready_w [2];
  logic [7:0]      byte_out_w [2];
  logic            valid_out_w [2];
  logic            msg_start_w [2];
  logic            msg_done_w [2];
  logic            busy_w [2];
  logic [15:0]     msg_count_w [2];

  int n_cmp;
  int n_fail;
  int cyc;

  // Reference model state, per DUT
  replace_fields_t wait_f [2][$];
  int              wait_acc [2][$];
  replace_fields_t off_q [2][$];
  bit              hold_off [2];
  bit              act [2];
  int              act_start [2];
  logic [215:0]    act_msg [2];
  int              next_free [2];
  int              last_end [2];
  bit              has_last [2];
  logic [15:0]     cnt_m [2];
  bit              exp_ready [2];
  logic [28:0]     exp_vec [2];

  replace_order_encoder #(.IDLE_GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_old_order_ref(in_f[0].old_ref), .in_new_order_ref(in_f[0].new_ref),
    .in_shares(in_f[0].shares), .in_price(in_f[0].price),
    .byte_out(byte_out_w[0]), .valid_out(valid_out_w[0]), .msg_start(msg_start_w[0]),
    .msg_done(msg_done_w[0]), .busy(busy_w[0]), .msg_count(msg_count_w[0])
  );

  replace_order_encoder #(.IDLE_GAP(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_old_order_ref(in_f[1].old_ref), .in_new_order_ref(in_f[1].new_ref),
    .in_shares(in_f[1].shares), .in_price(in_f[1].price),
    .byte_out(byte_out_w[1]), .valid_out(valid_out_w[1]), .msg_start(msg_start_w[1]),
    .msg_done(msg_done_w[1]), .busy(busy_w[1]), .msg_count(msg_count_w[1])
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int gap_len(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic replace_fields_t rand_fields();
    replace_fields_t f;
    f.old_ref = {$urandom, $urandom};
    f.new_ref = {$urandom, $urandom};
    f.shares  = $urandom;
    f.price   = $urandom;
    return f;
  endfunction

  function automatic logic [215:0] msg_image(replace_fields_t f);
    return {8'h55, f.old_ref, f.new_ref, f.shares, f.price, 16'h0000};
  endfunction

  function automatic logic [28:0] obs_vec(int d);
    return {valid_out_w[d], byte_out_w[d], msg_start_w[d], msg_done_w[d],
            in_ready_w[d], busy_w[d], msg_count_w[d]};
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      wait_f[d].delete();
      wait_acc[d].delete();
      off_q[d].delete();
      hold_off[d]  = 1'b0;
      act[d]       = 1'b0;
      act_start[d] = 0;
      next_free[d] = 0;
      last_end[d]  = 0;
      has_last[d]  = 1'b0;
      cnt_m[d]     = 16'h0000;
      exp_ready[d] = 1'b1;
      exp_vec[d]   = RST_VEC;
    end
  endtask

  // Message k starts at max(accept+1, previous last byte + 1 + gap) and runs 27 cycles
  task automatic model_step(int d, bit acc, replace_fields_t f);
    int idx;
    logic [215:0] m;
    logic [7:0] b;
    bit st, dn, in_gap;
    if (acc) begin
      wait_f[d].push_back(f);
      wait_acc[d].push_back(cyc);
    end
    if (act[d] && (cyc - act_start[d]) >= 27) begin
      act[d]       = 1'b0;
      last_end[d]  = act_start[d] + 26;
      has_last[d]  = 1'b1;
      next_free[d] = last_end[d] + 1 + gap_len(d);
    end
    if (!act[d] && wait_f[d].size() > 0) begin
      if (cyc > wait_acc[d][0] && cyc >= next_free[d]) begin
        act[d]       = 1'b1;
        act_start[d] = cyc;
        act_msg[d]   = msg_image(wait_f[d].pop_front());
        void'(wait_acc[d].pop_front());
      end
    end
    idx = cyc - act_start[d];
    b = 8'h00;
    if (act[d]) begin
      m = act_msg[d];
      b = m[215 - 8*idx -: 8];
    end
    st = act[d] && (idx == 0);
    dn = act[d] && (idx == 26);
    if (dn) cnt_m[d] = cnt_m[d] + 16'd1;
    in_gap = has_last[d] && (gap_len(d) > 0) && (cyc > last_end[d]) &&
             (cyc <= last_end[d] + gap_len(d));
    exp_ready[d] = (wait_f[d].size() == 0);
    exp_vec[d] = {act[d], b, st, dn, exp_ready[d],
                  act[d] || (wait_f[d].size() > 0) || in_gap, cnt_m[d]};
  endtask

  // Drive offers, advance one clock, update the model, land on the sampling edge
  task automatic tick();
    bit acc;
    for (int d = 0; d < 2; d++) begin
      if (off_q[d].size() > 0 && !hold_off[d]) begin
        in_valid[d] = 1'b1;
        in_f[d]     = off_q[d][0];
      end else begin
        in_valid[d] = 1'b0;
        in_f[d]     = rand_fields();
      end
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      acc = in_valid[d] && exp_ready[d];
      if (acc) void'(off_q[d].pop_front());
      model_step(d, acc, in_f[d]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_vec(d) !== RST_VEC) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h want %h", d, obs_vec(d), RST_VEC);
      end
    end
    rst_n = 1'b1;
    reset_model();
    repeat (3) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec[d]) begin
          n_fail++;
          $display("FAIL reset_idle dut%0d cyc%0d: got %h want %h", d, cyc, obs_vec(d), exp_vec[d]);
        end
      end
    end
  endtask

  task automatic test_single();
    replace_fields_t f;
    logic [215:0] coll;
    logic [215:0] want;
    int nv, first_v, last_v;
    want = 216'h55_0102030405060708_1112131415161718_000003E8_00989680_0000;
    f.old_ref = 64'h0102030405060708;
    f.new_ref = 64'h1112131415161718;
    f.shares  = 32'h000003E8;
    f.price   = 32'h00989680;
    for (int d = 0; d < 2; d++) off_q[d].push_back(f);
    coll = '0; nv = 0; first_v = -1; last_v = -1;
    for (int i = 0; i < 45; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec[d]) begin
          n_fail++;
          $display("FAIL single dut%0d cyc%0d: got %h want %h", d, cyc, obs_vec(d), exp_vec[d]);
        end
      end
      if (valid_out_w[0] === 1'b1) begin
        coll = {coll[207:0], byte_out_w[0]};
        nv++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
    end
    n_cmp++;
    if (coll !== want) begin
      n_fail++;
      $display("FAIL single_bytes: got %h want %h", coll, want);
    end
    n_cmp++;
    if (nv != 27 || (last_v - first_v) != 26) begin
      n_fail++;
      $display("FAIL single_contig: got %0d bytes over span %0d want 27 over 26", nv, last_v - first_v);
    end
    n_cmp++;
    if (msg_count_w[0] !== 16'd1 || msg_count_w[1] !== 16'd1) begin
      n_fail++;
      $display("FAIL single_count: got %0d/%0d want 1/1", msg_count_w[0], msg_count_w[1]);
    end
  endtask

  task automatic test_back_to_back();
    int s0 [$];
    for (int d = 0; d < 2; d++) begin
      off_q[d].push_back(rand_fields());
      off_q[d].push_back(rand_fields());
    end
    for (int i = 0; i < 80; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec[d]) begin
          n_fail++;
          $display("FAIL b2b dut%0d cyc%0d: got %h want %h", d, cyc, obs_vec(d), exp_vec[d]);
        end
      end
      if (msg_start_w[0] === 1'b1) s0.push_back(cyc);
    end
    n_cmp++;
    if (s0.size() != 2 || (s0.size() == 2 && s0[1] - s0[0] != 27)) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d starts, spacing %0d want 2 starts spacing 27",
               s0.size(), (s0.size() == 2) ? s0[1] - s0[0] : -1);
    end
  endtask

  task automatic test_gap();
    bit seen_done, seen_second;
    int zeros;
    for (int d = 0; d < 2; d++) begin
      off_q[d].push_back(rand_fields());
      off_q[d].push_back(rand_fields());
    end
    seen_done = 1'b0; seen_second = 1'b0; zeros = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec[d]) begin
          n_fail++;
          $display("FAIL gap dut%0d cyc%0d: got %h want %h", d, cyc, obs_vec(d), exp_vec[d]);
        end
      end
      if (seen_done && msg_start_w[1] === 1'b1) seen_second = 1'b1;
      if (seen_done && !seen_second && valid_out_w[1] === 1'b0 && byte_out_w[1] === 8'h00) zeros++;
      if (msg_done_w[1] === 1'b1) seen_done = 1'b1;
    end
    n_cmp++;
    if (!seen_second || zeros != 3) begin
      n_fail++;
      $display("FAIL gap_len: got %0d idle cycles (second seen %0d) want 3", zeros, seen_second);
    end
  endtask

  task automatic test_pending_full();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) off_q[d].push_back(rand_fields());
    for (int i = 0; i < 110; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec[d]) begin
          n_fail++;
          $display("FAIL pend_full dut%0d cyc%0d: got %h want %h", d, cyc, obs_vec(d), exp_vec[d]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    for (int d = 0; d < 2; d++) begin
      off_q[d].push_back(rand_fields());
      off_q[d].push_back(rand_fields());
    end
    budget = 60;
    do begin
      tick();
      budget--;
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec[d]) begin
          n_fail++;
          $display("FAIL reset_mid_pre dut%0d cyc%0d: got %h want %h", d, cyc, obs_vec(d), exp_vec[d]);
        end
      end
    end while (!(act[0] && (cyc - act_start[0]) == 10) && budget > 0);
    if (budget == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL reset_mid_wait: got no byte 10 within 60 cycles want byte 10");
    end
    #2 rst_n = 1'b0;
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_vec(d) !== RST_VEC) begin
        n_fail++;
        $display("FAIL reset_async dut%0d: got %h want %h", d, obs_vec(d), RST_VEC);
      end
    end
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) off_q[d].push_back(rand_fields());
    for (int i = 0; i < 50; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec[d]) begin
          n_fail++;
          $display("FAIL reset_mid_post dut%0d cyc%0d: got %h want %h", d, cyc, obs_vec(d), exp_vec[d]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 720; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (i < 600 && off_q[d].size() == 0 && ($urandom % 3) == 0) off_q[d].push_back(rand_fields());
        hold_off[d] = (i < 600) && (($urandom % 4) == 0);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec[d]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: got %h want %h", d, cyc, obs_vec(d), exp_vec[d]);
        end
      end
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b1;
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_f[d]     = '0;
    end
    reset_model();
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_pending_full();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
